// File: rtl/demux4_tdm_sched_if.sv
// Handshake and demux-control bundle between the source/sink logic and the
// TDM scheduler. The master side owns requests and source data. The slave
// side (the scheduler) owns ready, demux routing and the acknowledges.
interface demux4_tdm_sched_if;
    logic [3:0] REQ;   // per-sink bit request, level-sensitive
    logic       DV;    // source data valid
    logic       DIN;   // source data bit
    logic       DRDY;  // source ready
    logic [1:0] A;     // demux select
    logic       D;     // demux data bit
    logic       E;     // demux enable, active high
    logic [3:0] ACK;   // one-hot served-sink acknowledge
    logic       BUSY;  // slot in progress

    modport master (
        output REQ, DV, DIN,
        input  DRDY, A, D, E, ACK, BUSY
    );

    modport slave (
        input  REQ, DV, DIN,
        output DRDY, A, D, E, ACK, BUSY
    );
endinterface

// File: rtl/demux4_tdm_sched.sv
// Round-robin time-division scheduler feeding a 1-to-4 active-low demux.
// One source bit is accepted per slot. The winning sink's routing is held
// with E high for SLOT_LEN cycles, and the sink is acknowledged in the
// last slot cycle.
module demux4_tdm_sched #(
    parameter int SLOT_LEN = 4   // cycles E stays high per slot, 1..255
) (
    input  logic               CLK,
    input  logic               RST_N,
    demux4_tdm_sched_if.slave  bus
);

    typedef enum logic {IDLE, SLOT} state_t;

    localparam logic [7:0] LAST = 8'(SLOT_LEN - 1);

    state_t     state_q;
    logic [1:0] ptr_q;     // round-robin search start
    logic [7:0] cnt_q;     // cycles elapsed in current slot
    logic [1:0] a_q;       // latched grant, drives the demux select
    logic       d_q;       // latched source bit
    logic [1:0] grant_d;   // round-robin winner for the current REQ
    logic       any_req;
    logic       accept;

    assign any_req = |bus.REQ;

    // Ready is held low during reset so a source bit is never consumed then.
    assign accept  = RST_N && (state_q == IDLE) && bus.DV && any_req;

    // Round-robin winner: first set REQ bit starting at ptr_q, wrapping mod 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant_d = ptr_q;
        found   = 1'b0;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.REQ[idx]) begin
                grant_d = idx;
                found   = 1'b1;
            end
        end
    end

    // Scheduler FSM: IDLE waits for a handshake, SLOT holds routing for SLOT_LEN cycles.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            a_q     <= 2'd0;
            d_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= grant_d;
                        d_q     <= bus.DIN;
                        cnt_q   <= 8'd0;
                        ptr_q   <= grant_d + 2'd1;
                        state_q <= SLOT;
                    end
                end
                SLOT: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state; ACK is suppressed while reset is asserted
    // so an aborted slot is never acknowledged.
    assign bus.DRDY = accept;
    assign bus.A    = a_q;
    assign bus.D    = d_q;
    assign bus.E    = (state_q == SLOT);
    assign bus.BUSY = (state_q == SLOT);
    assign bus.ACK  = (RST_N && state_q == SLOT && cnt_q == LAST) ? (4'b0001 << a_q) : 4'b0000;

endmodule

// File: tb/tb_demux4_tdm_sched.sv
// Directed, table-driven bench for the TDM demux scheduler. Each table row
// gives the inputs applied for one clock cycle and the outputs expected in
// that cycle. A second instance with SLOT_LEN=1 covers the shortest slot.
module tb_demux4_tdm_sched;

    logic CLK;
    logic rst_n;
    logic rst_n1;

    demux4_tdm_sched_if bus0 ();
    demux4_tdm_sched_if bus1 ();

    demux4_tdm_sched #(.SLOT_LEN(4)) dut (
        .CLK   (CLK),
        .RST_N (rst_n),
        .bus   (bus0)
    );

    demux4_tdm_sched #(.SLOT_LEN(1)) dut1 (
        .CLK   (CLK),
        .RST_N (rst_n1),
        .bus   (bus1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       dv;
        logic       din;
        logic       drdy;
        logic [1:0] a;
        logic       d;
        logic       e;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    vec_t       vq[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [1:0] la = 2'd0;   // A value the demux select should be holding
    logic       ld = 1'b0;   // D value the demux data should be holding

    // Output of an active-low 1-to-4 demux driven by A and E.
    function automatic logic [3:0] demux_out(input logic [1:0] a, input logic e);
        return e ? ~(4'b0001 << a) : 4'b1111;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] req, input logic dv, input logic din,
                       input logic drdy, input logic [1:0] a, input logic d, input logic e,
                       input logic [3:0] ack, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.dv = dv; v.din = din; v.drdy = drdy;
        v.a = a; v.d = d; v.e = e; v.ack = ack; v.busy = busy;
        vq.push_back(v);
    endtask

    // Handshake cycle followed by a 4-cycle slot to sink g. During the slot DV
    // stays high and DIN is inverted, both of which the slot must ignore.
    task automatic add_xfer(input logic [3:0] hs_req, input logic [3:0] slot_req,
                            input logic din, input logic [1:0] g);
        add(1'b1, hs_req, 1'b1, din, 1'b1, la, ld, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b1, slot_req, 1'b1, ~din, 1'b0, g, din, 1'b1,
                (k == 3) ? (4'b0001 << g) : 4'b0000, 1'b1);
        la = g;
        ld = din;
    endtask

    initial begin
        // Reset held with every request and DV high: nothing may be granted.
        add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Round-robin with all sinks requesting: grants 0,1,2,3,0.
        add_xfer(4'b1111, 4'b1111, 1'b1, 2'd0);
        add_xfer(4'b1111, 4'b1111, 1'b0, 2'd1);
        add_xfer(4'b1111, 4'b1111, 1'b1, 2'd2);
        add_xfer(4'b1111, 4'b1111, 1'b1, 2'd3);
        add_xfer(4'b1111, 4'b1111, 1'b0, 2'd0);

        // DV high but no request: not ready.
        add(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, la, ld, 1'b0, 4'b0000, 1'b0);

        // Single transfer to sink 2 with DIN=0 (pointer was 1).
        add_xfer(4'b0100, 4'b0100, 1'b0, 2'd2);

        // Stall: request without DV for 5 cycles.
        for (int k = 0; k < 5; k++)
            add(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, la, ld, 1'b0, 4'b0000, 1'b0);
        add_xfer(4'b0010, 4'b0010, 1'b1, 2'd1);

        // Pointer skip: pointer is 2 and only sink 0 requests.
        add_xfer(4'b0001, 4'b0001, 1'b0, 2'd0);
        // Pointer must now be 1.
        add_xfer(4'b1111, 4'b1111, 1'b1, 2'd1);

        // Request dropped during the slot: slot still completes with ACK.
        add_xfer(4'b1000, 4'b0000, 1'b0, 2'd3);

        // Reset at the second slot cycle of a grant to sink 2 (pointer moves to 3).
        add(1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, la, ld, 1'b0, 4'b0000, 1'b0);
        add(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b1);
        la = 2'd0;
        ld = 1'b0;
        // After reset the pointer is 0, so sink 0 wins rather than sink 3.
        add_xfer(4'b1111, 4'b1111, 1'b0, 2'd0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, la, ld, 1'b0, 4'b0000, 1'b0);

        // Initial reset of both instances.
        rst_n     = 1'b0;
        rst_n1    = 1'b0;
        bus0.REQ  = 4'b1111;
        bus0.DV   = 1'b1;
        bus0.DIN  = 1'b1;
        bus1.REQ  = 4'b0000;
        bus1.DV   = 1'b0;
        bus1.DIN  = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);

        foreach (vq[i]) begin
            rst_n    = vq[i].rst;
            bus0.REQ = vq[i].req;
            bus0.DV  = vq[i].dv;
            bus0.DIN = vq[i].din;
            #1;
            chk("DRDY", i, 8'(bus0.DRDY), 8'(vq[i].drdy));
            chk("A",    i, 8'(bus0.A),    8'(vq[i].a));
            chk("D",    i, 8'(bus0.D),    8'(vq[i].d));
            chk("E",    i, 8'(bus0.E),    8'(vq[i].e));
            chk("ACK",  i, 8'(bus0.ACK),  8'(vq[i].ack));
            chk("BUSY", i, 8'(bus0.BUSY), 8'(vq[i].busy));
            chk("DEMUX", i, 8'(demux_out(bus0.A, bus0.E)), 8'(demux_out(vq[i].a, vq[i].e)));
            @(negedge CLK);
        end

        // SLOT_LEN=1: E high for exactly one cycle, ACK in that cycle,
        // and ready again in the very next cycle.
        rst_n1   = 1'b1;
        bus1.REQ = 4'b0010;
        bus1.DV  = 1'b1;
        bus1.DIN = 1'b1;
        #1;
        chk("S1_DRDY", 0, 8'(bus1.DRDY), 8'd1);
        chk("S1_E",    0, 8'(bus1.E),    8'd0);
        @(negedge CLK);
        bus1.DIN = 1'b0;
        #1;
        chk("S1_DRDY", 1, 8'(bus1.DRDY), 8'd0);
        chk("S1_E",    1, 8'(bus1.E),    8'd1);
        chk("S1_A",    1, 8'(bus1.A),    8'd1);
        chk("S1_D",    1, 8'(bus1.D),    8'd1);
        chk("S1_ACK",  1, 8'(bus1.ACK),  8'h2);
        chk("S1_BUSY", 1, 8'(bus1.BUSY), 8'd1);
        @(negedge CLK);
        #1;
        chk("S1_DRDY", 2, 8'(bus1.DRDY), 8'd1);
        chk("S1_E",    2, 8'(bus1.E),    8'd0);
        chk("S1_ACK",  2, 8'(bus1.ACK),  8'h0);
        chk("S1_A",    2, 8'(bus1.A),    8'd1);
        @(negedge CLK);
        bus1.REQ = 4'b0000;
        bus1.DV  = 1'b0;
        #1;
        chk("S1_E",    3, 8'(bus1.E),    8'd1);
        chk("S1_D",    3, 8'(bus1.D),    8'd0);
        chk("S1_ACK",  3, 8'(bus1.ACK),  8'h2);
        @(negedge CLK);
        #1;
        chk("S1_E",    4, 8'(bus1.E),    8'd0);
        chk("S1_ACK",  4, 8'(bus1.ACK),  8'h0);
        chk("S1_BUSY", 4, 8'(bus1.BUSY), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/demux4_tdm_sched.md
# demux4_tdm_sched

Time-division scheduler that drives the select, enable and data inputs of the 1-to-4 active-low demultiplexer (`demus_4`). Four sink channels request bits, and a serial source offers bits through a valid/ready handshake. The block grants one sink per slot in round-robin order and holds the demux routing for a programmable slot length. It then acknowledges the served sink. It sits directly between the source/sink control logic and the demux instance.

## Interface
- SLOT_LEN, default 4: cycles E is held high per slot; legal range 1..255.
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  reset; one clock; reset is synchronous and active-low.
- REQ  in  4  per-sink request, bit i = sink i wants a bit; level-sensitive.
- DV  in  1  source data valid.
- DIN  in  1  source data bit, sampled when DV & DRDY.
- DRDY  out  1  source ready (combinational); transfer occurs on the edge where DV & DRDY.
- A  out  2  demux select (granted sink index).
- D  out  1  demux data bit.
- E  out  1  demux enable, active high.
- ACK  out  4  one-hot, one-cycle served-sink acknowledge.
- BUSY  out  1  high while a slot is in progress.

## Operation
- States: IDLE, SLOT. Internal state: 2-bit round-robin pointer PTR, 8-bit slot counter CNT, latched grant G.
- **Reset values:** RST_N low at a rising edge sets the following:
  - state = IDLE, PTR = 0, CNT = 0, A = 2'b00, D = 0, E = 0, BUSY = 0.
  - ACK = 4'b0000 and DRDY = 0 while state is IDLE with no eligible request.
  - With E = 0, the demux output is 4'b1111.
- **IDLE:**
  - DRDY = DV & |REQ.
  - The grant G is the first set REQ bit searched in the order PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - When DV & |REQ at an edge:
    - A <= G, D <= DIN, CNT <= 0, PTR <= (G+1) mod 4, state <= SLOT.
  - Otherwise remain in IDLE; A and D hold their last values.
- **SLOT:**
  - E = 1, BUSY = 1, DRDY = 0.
  - CNT increments each cycle.
  - In the cycle where CNT == SLOT_LEN-1:
    - ACK[A] = 1 (combinational; all other ACK bits 0).
    - At the following edge: state <= IDLE, CNT <= 0.
- A slot always runs to completion; REQ or DV changes during SLOT are ignored.
- A and D are registered and stable for the whole slot; they retain their values after the slot ends (E = 0 masks them at the demux).
- PTR advances only on an accepted transfer, never on idle cycles.

## Timing
- Handshake edge t (IDLE, DV=1, some REQ=1):
  - Cycles t+1 .. t+SLOT_LEN: E=1, A=G, D=bit.
  - ACK[G] is asserted in cycle t+SLOT_LEN.
  - Cycle t+SLOT_LEN+1: IDLE, E=0; DRDY may assert again in this same cycle.
- Peak throughput: one bit per SLOT_LEN+1 cycles.
- SLOT_LEN=1: E is high for exactly one cycle, and ACK coincides with that cycle.
- REQ high but DV low: stay in IDLE, DRDY=0, no grant is computed into state, PTR is unchanged.
- DV high but REQ=0: DRDY=0; the bit is not consumed.
- Reset mid-slot: at the reset edge E drops to 0 and no ACK is issued for the aborted slot. The next cycle after reset release is IDLE with PTR=0.
- Simultaneous requests: only the round-robin winner is served; losers keep REQ asserted and are served in later slots without starvation (at most 3 intervening slots).

## Test plan
- **Reset:** hold RST_N=0 for 2 cycles with REQ=4'b1111, DV=1 -> E=0, A=00, D=0, ACK=0, DRDY=0, BUSY=0; the demux reads 4'b1111.
- **Single transfer, SLOT_LEN=4:** REQ=4'b0100, DV=1, DIN=0 at edge t -> cycles t+1..t+4: A=2'b10, D=0, E=1, and the demux reads 4'b1011. ACK=4'b0100 only in t+4; E=0 at t+5.
- **Round-robin fairness:** REQ=4'b1111, DV=1 continuously -> grants in order 0,1,2,3,0. Each E pulse is 4 cycles, separated by one idle cycle, and ACK walks 0001, 0010, 0100, 1000.
- **Pointer skip:** after a grant to sink 1, set REQ=4'b0001 -> next grant is sink 0, and PTR becomes 1.
- **Stalls:** with REQ=4'b0010 and DV=0 for 5 cycles -> no E and no DRDY. Raising DV gives DRDY=1 the same cycle and a slot to sink 1 starting on the next cycle.
- **Mid-slot events:** drop REQ during a slot -> the slot completes and ACK is still issued. Assert RST_N=0 at the second slot cycle -> E=0 at the following edge, no ACK, PTR=0.
